ysyx_23060025_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060025_mem_arbiter

Overview:
- Shares the single AXI-lite memory port between two masters: IFU (M0, read-only) and LSU (M1, read and write).
- Grants one transaction at a time. The grant is held from request until the response handshake completes, so there are no outstanding or interleaved transactions.
- Sits between the IFU/LSU bus masters and the SoC crossbar/memory slave.

Parameters:
- DATA_LEN, 32, data bus width
- ADDR_LEN, 32, address bus width

Ports:
- clock  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m0_ar_addr_i  in  ADDR_LEN  IFU read address
- m0_ar_valid_i  in  1  IFU read address valid
- m0_ar_size_i  in  3  IFU read size
- m0_ar_ready_o  out  1  IFU read address accepted
- m0_r_data_o  out  DATA_LEN  IFU read data
- m0_r_resp_o  out  2  IFU read response
- m0_r_valid_o  out  1  IFU read data valid
- m0_r_ready_i  in  1  IFU ready for read data
- m1_ar_addr_i / m1_ar_valid_i / m1_ar_size_i / m1_ar_ready_o  LSU read address channel, widths as M0
- m1_r_data_o / m1_r_resp_o / m1_r_valid_o / m1_r_ready_i  LSU read data channel, widths as M0
- m1_aw_addr_i  in  ADDR_LEN  LSU write address
- m1_aw_valid_i  in  1  LSU write address valid
- m1_aw_size_i  in  3  LSU write size
- m1_aw_ready_o  out  1  LSU write address accepted
- m1_w_data_i  in  DATA_LEN  LSU write data
- m1_w_strb_i  in  4  LSU byte strobes
- m1_w_valid_i  in  1  LSU write data valid
- m1_w_ready_o  out  1  LSU write data accepted
- m1_b_resp_o  out  2  LSU write response
- m1_b_valid_o  out  1  LSU write response valid
- m1_b_ready_i  in  1  LSU ready for write response
- s_ar_*, s_r_*, s_aw_*, s_w_*, s_b_*  mirror of the M1 channel set toward the slave, directions reversed, same widths

Behaviour:
- Reset (async, rstn=0): state=IDLE, owner=M0, aw_done=w_done=0. Every valid and ready output is 0; every slave address/data/size/strb output is 0.
- States: IDLE, ADDR, RESP. Transaction type is rd or wr.
- IDLE:
  - Requests: req0=m0_ar_valid_i; req1=m1_ar_valid_i|m1_aw_valid_i.
  - Winner on conflict is M1 (fixed priority).
  - Registers the winner as owner. Type is rd for M0; for M1, rd if m1_ar_valid_i else wr (read wins if both are asserted).
  - Next state is ADDR. Arbitration latency is 1 cycle; no master sees a ready in IDLE.
- ADDR, rd:
  - s_ar_addr/size/valid driven from the owner; owner ar_ready = s_ar_ready_i.
  - On s_ar handshake, go to RESP.
- ADDR, wr:
  - AW and W forwarded independently.
  - aw_done is set on the AW handshake, w_done on the W handshake; each valid is masked once its done flag is set.
  - Go to RESP in the cycle both are done; same-cycle handshakes are allowed.
- RESP, rd:
  - s_r_* forwarded to the owner only; s_r_ready_o = owner r_ready.
  - On handshake, go to IDLE; the response value (including error resp) is passed unchanged.
- RESP, wr:
  - s_b_* forwarded to M1; s_b_ready_o = m1_b_ready_i.
  - On handshake, go to IDLE and clear the done flags.
- Non-owner: all readies and response valids are 0; its requests wait. Back-to-back transactions cost one IDLE cycle each.
- Outputs are combinational from state, owner and type. In IDLE, all slave outputs are 0.
- Slave valids stay asserted until handshake, independent of master valid drop. The owner is required to hold its valid; behaviour is undefined if it does not.
- Reset mid-transaction returns to IDLE at once. No response is delivered for the aborted transaction.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Adds a last_owner register, reset to M1, updated on every completion.
  - On a conflict in IDLE, the master that is not last_owner wins.
- ARB_ROUND_ROBIN_EN undefined: fixed M1 priority, no extra register.

Decomposition:
- Shared define file holds:
  - state encodings ARB_IDLE=2'b00, ARB_ADDR=2'b01, ARB_RESP=2'b10
  - owner encodings ARB_M0=1'b0, ARB_M1=1'b1
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10
- Sub-module ysyx_23060025_arb_grant: combinational winner select plus the optional last_owner register.

Test Plan:
- M0 ar addr 0x30000000, slave ready after 2 cycles, r_data 0xDEADBEEF -> m0_ar_ready 1 cycle after s_ar handshake path opens; m0_r_data=0xDEADBEEF; m1 sees no valid.
- Both request in the same IDLE cycle (M0 ar 0x30000004, M1 ar 0x0F000000) -> M1 served first, M0 granted in the IDLE after M1's R handshake. With ARB_ROUND_ROBIN_EN and last_owner=M1, M0 is served first.
- M1 write addr 0x0F000010, data 0x12345678, strb 4'b1111, W accepted 3 cycles before AW -> s_w_valid drops after the W handshake; RESP entered only after AW; b_resp 2'b00 reaches M1.
- Slave returns r_resp 2'b10 for M1 read -> m1_r_resp_o=2'b10, state returns to IDLE.
- rstn pulled low during RESP of an M0 read -> all valids 0 immediately; after release, a fresh M0 request is granted normally.
- M1 asserts ar_valid and aw_valid together -> read performed first; write granted in the following transaction.

Source files
------------

// File: rtl/ysyx_23060025_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids,
// transaction type and AXI response codes.
package ysyx_23060025_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_owner_e;

  typedef enum logic {
    TXN_RD = 1'b0,
    TXN_WR = 1'b1
  } arb_txn_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060025_mem_arbiter_grant.sv
// Winner select for the memory arbiter. With ARB_ROUND_ROBIN_EN defined a
// last_owner register alternates the winner on conflicts; otherwise M1 wins.
module ysyx_23060025_arb_grant
  import ysyx_23060025_mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       rstn,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       done_i,
  input  arb_owner_e owner_i,
  output arb_owner_e winner_o
);

  arb_owner_e conflict_pick;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner_q, last_owner_d;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) last_owner_q <= ARB_M1;
    else       last_owner_q <= last_owner_d;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (done_i) last_owner_d = owner_i;
  end

  assign conflict_pick = (last_owner_q == ARB_M1) ? ARB_M0 : ARB_M1;
`else
  // Fixed priority needs no history; these inputs exist only for the round-robin build.
  logic unused_rr;
  assign unused_rr     = ^{clock, rstn, done_i, owner_i};
  assign conflict_pick = ARB_M1;
`endif

  always_comb begin
    winner_o = ARB_M0;
    if (req0_i && req1_i) winner_o = conflict_pick;
    else if (req1_i)      winner_o = ARB_M1;
  end

endmodule

// File: rtl/ysyx_23060025_mem_arbiter.sv
// Shares one AXI-lite slave port between IFU (M0, read) and LSU (M1, read/write),
// one transaction at a time. Optional round-robin arbitration: ARB_ROUND_ROBIN_EN.
module ysyx_23060025_mem_arbiter
  import ysyx_23060025_mem_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] m0_ar_addr_i,
  input  logic                m0_ar_valid_i,
  input  logic [2:0]          m0_ar_size_i,
  output logic                m0_ar_ready_o,
  output logic [DATA_LEN-1:0] m0_r_data_o,
  output logic [1:0]          m0_r_resp_o,
  output logic                m0_r_valid_o,
  input  logic                m0_r_ready_i,
  input  logic [ADDR_LEN-1:0] m1_ar_addr_i,
  input  logic                m1_ar_valid_i,
  input  logic [2:0]          m1_ar_size_i,
  output logic                m1_ar_ready_o,
  output logic [DATA_LEN-1:0] m1_r_data_o,
  output logic [1:0]          m1_r_resp_o,
  output logic                m1_r_valid_o,
  input  logic                m1_r_ready_i,
  input  logic [ADDR_LEN-1:0] m1_aw_addr_i,
  input  logic                m1_aw_valid_i,
  input  logic [2:0]          m1_aw_size_i,
  output logic                m1_aw_ready_o,
  input  logic [DATA_LEN-1:0] m1_w_data_i,
  input  logic [3:0]          m1_w_strb_i,
  input  logic                m1_w_valid_i,
  output logic                m1_w_ready_o,
  output logic [1:0]          m1_b_resp_o,
  output logic                m1_b_valid_o,
  input  logic                m1_b_ready_i,
  output logic [ADDR_LEN-1:0] s_ar_addr_o,
  output logic                s_ar_valid_o,
  output logic [2:0]          s_ar_size_o,
  input  logic                s_ar_ready_i,
  input  logic [DATA_LEN-1:0] s_r_data_i,
  input  logic [1:0]          s_r_resp_i,
  input  logic                s_r_valid_i,
  output logic                s_r_ready_o,
  output logic [ADDR_LEN-1:0] s_aw_addr_o,
  output logic                s_aw_valid_o,
  output logic [2:0]          s_aw_size_o,
  input  logic                s_aw_ready_i,
  output logic [DATA_LEN-1:0] s_w_data_o,
  output logic [3:0]          s_w_strb_o,
  output logic                s_w_valid_o,
  input  logic                s_w_ready_i,
  input  logic [1:0]          s_b_resp_i,
  input  logic                s_b_valid_i,
  output logic                s_b_ready_o
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d, winner;
  arb_txn_e   txn_q, txn_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       req0, req1, txn_done;
  logic       rd_addr, wr_addr, rd_resp, wr_resp;

  // The slave W valid is held by the arbiter until handshake, so the master's W valid is not consulted.
  logic unused_w_valid;
  assign unused_w_valid = m1_w_valid_i;

  assign req0    = m0_ar_valid_i;
  assign req1    = m1_ar_valid_i | m1_aw_valid_i;
  assign rd_addr = (state_q == ARB_ADDR) && (txn_q == TXN_RD);
  assign wr_addr = (state_q == ARB_ADDR) && (txn_q == TXN_WR);
  assign rd_resp = (state_q == ARB_RESP) && (txn_q == TXN_RD);
  assign wr_resp = (state_q == ARB_RESP) && (txn_q == TXN_WR);

  ysyx_23060025_arb_grant u_grant (
    .clock    (clock),
    .rstn     (rstn),
    .req0_i   (req0),
    .req1_i   (req1),
    .done_i   (txn_done),
    .owner_i  (owner_q),
    .winner_o (winner)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_M0;
      txn_q     <= TXN_RD;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      txn_q     <= txn_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    m0_ar_ready_o = 1'b0;
    m0_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m0_r_valid_o  = 1'b0;
    m1_ar_ready_o = 1'b0;
    m1_r_data_o   = '0;
    m1_r_resp_o   = 2'b00;
    m1_r_valid_o  = 1'b0;
    m1_aw_ready_o = 1'b0;
    m1_w_ready_o  = 1'b0;
    m1_b_resp_o   = 2'b00;
    m1_b_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_ar_valid_o  = 1'b0;
    s_ar_size_o   = 3'b000;
    s_r_ready_o   = 1'b0;
    s_aw_addr_o   = '0;
    s_aw_valid_o  = 1'b0;
    s_aw_size_o   = 3'b000;
    s_w_data_o    = '0;
    s_w_strb_o    = 4'b0000;
    s_w_valid_o   = 1'b0;
    s_b_ready_o   = 1'b0;

    if (rd_addr) begin
      s_ar_valid_o = 1'b1;
      if (owner_q == ARB_M1) begin
        s_ar_addr_o   = m1_ar_addr_i;
        s_ar_size_o   = m1_ar_size_i;
        m1_ar_ready_o = s_ar_ready_i;
      end else begin
        s_ar_addr_o   = m0_ar_addr_i;
        s_ar_size_o   = m0_ar_size_i;
        m0_ar_ready_o = s_ar_ready_i;
      end
    end

    // AW and W complete independently; each channel goes quiet once its handshake is recorded.
    if (wr_addr) begin
      s_aw_addr_o   = m1_aw_addr_i;
      s_aw_size_o   = m1_aw_size_i;
      s_aw_valid_o  = !aw_done_q;
      m1_aw_ready_o = !aw_done_q && s_aw_ready_i;
      s_w_data_o    = m1_w_data_i;
      s_w_strb_o    = m1_w_strb_i;
      s_w_valid_o   = !w_done_q;
      m1_w_ready_o  = !w_done_q && s_w_ready_i;
    end

    if (rd_resp) begin
      if (owner_q == ARB_M1) begin
        m1_r_data_o  = s_r_data_i;
        m1_r_resp_o  = s_r_resp_i;
        m1_r_valid_o = s_r_valid_i;
        s_r_ready_o  = m1_r_ready_i;
      end else begin
        m0_r_data_o  = s_r_data_i;
        m0_r_resp_o  = s_r_resp_i;
        m0_r_valid_o = s_r_valid_i;
        s_r_ready_o  = m0_r_ready_i;
      end
    end

    if (wr_resp) begin
      m1_b_resp_o  = s_b_resp_i;
      m1_b_valid_o = s_b_valid_i;
      s_b_ready_o  = m1_b_ready_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    txn_d     = txn_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    txn_done  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          txn_d   = (winner == ARB_M1 && !m1_ar_valid_i) ? TXN_WR : TXN_RD;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (txn_q == TXN_RD) begin
          if (s_ar_valid_o && s_ar_ready_i) state_d = ARB_RESP;
        end else begin
          if (s_aw_valid_o && s_aw_ready_i) aw_done_d = 1'b1;
          if (s_w_valid_o && s_w_ready_i)   w_done_d  = 1'b1;
          if (aw_done_d && w_done_d)        state_d   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if ((rd_resp && s_r_valid_i && s_r_ready_o) ||
            (wr_resp && s_b_valid_i && s_b_ready_o)) begin
          state_d   = ARB_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          txn_done  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Directed bench for the memory arbiter: a reactive slave model, master tasks,
// and a response scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_ysyx_23060025_mem_arbiter;

  logic        clock, rstn;
  logic [31:0] m0_ar_addr_i;  logic m0_ar_valid_i; logic [2:0] m0_ar_size_i; logic m0_ar_ready_o;
  logic [31:0] m0_r_data_o;   logic [1:0] m0_r_resp_o; logic m0_r_valid_o; logic m0_r_ready_i;
  logic [31:0] m1_ar_addr_i;  logic m1_ar_valid_i; logic [2:0] m1_ar_size_i; logic m1_ar_ready_o;
  logic [31:0] m1_r_data_o;   logic [1:0] m1_r_resp_o; logic m1_r_valid_o; logic m1_r_ready_i;
  logic [31:0] m1_aw_addr_i;  logic m1_aw_valid_i; logic [2:0] m1_aw_size_i; logic m1_aw_ready_o;
  logic [31:0] m1_w_data_i;   logic [3:0] m1_w_strb_i; logic m1_w_valid_i; logic m1_w_ready_o;
  logic [1:0]  m1_b_resp_o;   logic m1_b_valid_o; logic m1_b_ready_i;
  logic [31:0] s_ar_addr_o;   logic s_ar_valid_o; logic [2:0] s_ar_size_o; logic s_ar_ready_i;
  logic [31:0] s_r_data_i;    logic [1:0] s_r_resp_i; logic s_r_valid_i; logic s_r_ready_o;
  logic [31:0] s_aw_addr_o;   logic s_aw_valid_o; logic [2:0] s_aw_size_o; logic s_aw_ready_i;
  logic [31:0] s_w_data_o;    logic [3:0] s_w_strb_o; logic s_w_valid_o; logic s_w_ready_i;
  logic [1:0]  s_b_resp_i;    logic s_b_valid_i; logic s_b_ready_o;

  ysyx_23060025_mem_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock(clock), .rstn(rstn),
    .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_size_i(m0_ar_size_i), .m0_ar_ready_o(m0_ar_ready_o),
    .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o), .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i),
    .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_size_i(m1_ar_size_i), .m1_ar_ready_o(m1_ar_ready_o),
    .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o), .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i),
    .m1_aw_addr_i(m1_aw_addr_i), .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_size_i(m1_aw_size_i), .m1_aw_ready_o(m1_aw_ready_o),
    .m1_w_data_i(m1_w_data_i), .m1_w_strb_i(m1_w_strb_i), .m1_w_valid_i(m1_w_valid_i), .m1_w_ready_o(m1_w_ready_o),
    .m1_b_resp_o(m1_b_resp_o), .m1_b_valid_o(m1_b_valid_o), .m1_b_ready_i(m1_b_ready_i),
    .s_ar_addr_o(s_ar_addr_o), .s_ar_valid_o(s_ar_valid_o), .s_ar_size_o(s_ar_size_o), .s_ar_ready_i(s_ar_ready_i),
    .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i), .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o),
    .s_aw_addr_o(s_aw_addr_o), .s_aw_valid_o(s_aw_valid_o), .s_aw_size_o(s_aw_size_o), .s_aw_ready_i(s_aw_ready_i),
    .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o), .s_w_valid_o(s_w_valid_o), .s_w_ready_i(s_w_ready_i),
    .s_b_resp_i(s_b_resp_i), .s_b_valid_i(s_b_valid_i), .s_b_ready_o(s_b_ready_o)
  );

  typedef struct { logic [31:0] addr; logic [2:0] size; } addrExp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } wExp_t;
  typedef struct { int kind; logic [31:0] data; logic [1:0] resp; } rspExp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } slvR_t;

  addrExp_t   expArQ[$], expAwQ[$];
  wExp_t      expWQ[$];
  rspExp_t    expRspQ[$];
  slvR_t      slvRQ[$];
  logic [1:0] slvBQ[$];

  int vecCount = 0;
  int missCount = 0;

  int arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
  int arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0;
  logic rPend = 0, awGot = 0, wGot = 0, wOnlyChecked = 0;
  logic arHs = 0, rHs = 0, awHs = 0, wHs = 0, bHs = 0;
  logic [31:0] rD = 0;
  logic [1:0]  rR = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkRsp(input int kind, input logic [31:0] data, input logic [1:0] resp);
    rspExp_t e;
    if (expRspQ.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL unexpected response: got kind %0d, expected none", kind);
      return;
    end
    e = expRspQ.pop_front();
    checkOutput("rsp owner/kind", kind, e.kind);
    if (kind != 2) checkOutput("r data", data, e.data);
    checkOutput("rsp code", 32'(resp), 32'(e.resp));
  endtask

  // Response monitor: a valid with ready high handshakes at the next rising edge.
  initial begin
    forever begin
      @(negedge clock); #2;
      if (m0_r_valid_o && m0_r_ready_i) checkRsp(0, m0_r_data_o, m0_r_resp_o);
      if (m1_r_valid_o && m1_r_ready_i) checkRsp(1, m1_r_data_o, m1_r_resp_o);
      if (m1_b_valid_o && m1_b_ready_i) checkRsp(2, 32'h0, m1_b_resp_o);
    end
  end

  task automatic clearSlave();
    s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = 0; s_r_resp_i = 0;
    s_aw_ready_i = 0; s_w_ready_i = 0; s_b_valid_i = 0; s_b_resp_i = 0;
    arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
    rPend = 0; awGot = 0; wGot = 0; wOnlyChecked = 0;
  endtask

  // Slave model: drives on the falling edge, then records which handshakes will fire next rise.
  initial begin
    slvR_t sr;
    addrExp_t ea;
    wExp_t ew;
    clearSlave();
    forever begin
      @(negedge clock);
      if (!rstn) begin
        clearSlave();
      end else begin
        if (arHs) begin
          s_ar_ready_i = 0; arCnt = 0;
          sr = (slvRQ.size() != 0) ? slvRQ.pop_front() : '{32'h0, 2'b00};
          rD = sr.data; rR = sr.resp; rPend = 1; rCnt = 0;
        end else if (s_ar_valid_o && !s_ar_ready_i) begin
          if (arCnt >= arDelay) s_ar_ready_i = 1; else arCnt++;
        end
        if (rHs) begin
          s_r_valid_i = 0; s_r_data_i = 0; s_r_resp_i = 0; rPend = 0;
        end else if (rPend && !s_r_valid_i) begin
          if (rCnt >= rDelay) begin s_r_valid_i = 1; s_r_data_i = rD; s_r_resp_i = rR; end
          else rCnt++;
        end
        if (awHs) begin
          s_aw_ready_i = 0; awCnt = 0; awGot = 1;
        end else if (s_aw_valid_o && !s_aw_ready_i) begin
          if (awCnt >= awDelay) s_aw_ready_i = 1; else awCnt++;
        end
        if (wHs) begin
          s_w_ready_i = 0; wCnt = 0; wGot = 1;
        end else if (s_w_valid_o && !s_w_ready_i) begin
          if (wCnt >= wDelay) s_w_ready_i = 1; else wCnt++;
        end
        if (bHs) begin
          s_b_valid_i = 0; s_b_resp_i = 0; awGot = 0; wGot = 0; wOnlyChecked = 0; bCnt = 0;
        end else if (awGot && wGot && !s_b_valid_i) begin
          if (bCnt >= bDelay) begin
            s_b_valid_i = 1;
            s_b_resp_i = (slvBQ.size() != 0) ? slvBQ.pop_front() : 2'b00;
          end else bCnt++;
        end
      end
      #1;
      arHs = s_ar_valid_o & s_ar_ready_i;
      rHs  = s_r_valid_i & s_r_ready_o;
      awHs = s_aw_valid_o & s_aw_ready_i;
      wHs  = s_w_valid_o & s_w_ready_i;
      bHs  = s_b_valid_i & s_b_ready_o;
      if (arHs) begin
        ea = (expArQ.size() != 0) ? expArQ.pop_front() : '{32'hFFFF_FFFF, 3'b111};
        checkOutput("s_ar_addr", s_ar_addr_o, ea.addr);
        checkOutput("s_ar_size", 32'(s_ar_size_o), 32'(ea.size));
      end
      if (awHs) begin
        ea = (expAwQ.size() != 0) ? expAwQ.pop_front() : '{32'hFFFF_FFFF, 3'b111};
        checkOutput("s_aw_addr", s_aw_addr_o, ea.addr);
      end
      if (wHs) begin
        ew = (expWQ.size() != 0) ? expWQ.pop_front() : '{32'hFFFF_FFFF, 4'h0};
        checkOutput("s_w_data", s_w_data_o, ew.data);
        checkOutput("s_w_strb", 32'(s_w_strb_o), 32'(ew.strb));
      end
      if (rstn && wGot && !awGot && !wOnlyChecked) begin
        wOnlyChecked = 1;
        checkOutput("s_w_valid after W hs", 32'(s_w_valid_o), 32'd0);
        checkOutput("s_b_ready before AW hs", 32'(s_b_ready_o), 32'd0);
      end
    end
  end

  task automatic m0Read(input logic [31:0] addr);
    int n = 0;
    m0_ar_addr_i = addr; m0_ar_size_i = 3'd2; m0_ar_valid_i = 1;
    do begin @(negedge clock); #1; n++; end while (!m0_ar_ready_o && n < 200);
    if (!m0_ar_ready_o) begin
      vecCount++; missCount++;
      $display("[TB] FAIL m0 ar timeout: got no ready, expected ready within 200 cycles");
    end
    @(posedge clock); #1;
    m0_ar_valid_i = 0; m0_ar_addr_i = 0;
  endtask

  task automatic m1Read(input logic [31:0] addr, input logic [2:0] size);
    int n = 0;
    m1_ar_addr_i = addr; m1_ar_size_i = size; m1_ar_valid_i = 1;
    do begin @(negedge clock); #1; n++; end while (!m1_ar_ready_o && n < 200);
    if (!m1_ar_ready_o) begin
      vecCount++; missCount++;
      $display("[TB] FAIL m1 ar timeout: got no ready, expected ready within 200 cycles");
    end
    @(posedge clock); #1;
    m1_ar_valid_i = 0; m1_ar_addr_i = 0;
  endtask

  task automatic m1Write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    m1_aw_addr_i = addr; m1_aw_size_i = 3'd2; m1_aw_valid_i = 1;
    m1_w_data_i = data; m1_w_strb_i = strb; m1_w_valid_i = 1;
    fork
      begin
        int n = 0;
        do begin @(negedge clock); #1; n++; end while (!m1_aw_ready_o && n < 200);
        if (!m1_aw_ready_o) begin
          vecCount++; missCount++;
          $display("[TB] FAIL m1 aw timeout: got no ready, expected ready within 200 cycles");
        end
        @(posedge clock); #1;
        m1_aw_valid_i = 0;
      end
      begin
        int n = 0;
        do begin @(negedge clock); #1; n++; end while (!m1_w_ready_o && n < 200);
        if (!m1_w_ready_o) begin
          vecCount++; missCount++;
          $display("[TB] FAIL m1 w timeout: got no ready, expected ready within 200 cycles");
        end
        @(posedge clock); #1;
        m1_w_valid_i = 0;
      end
    join
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expRspQ.size() != 0 && n < 300) begin @(negedge clock); n++; end
    vecCount++;
    if (expRspQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL %s drain: got %0d responses outstanding, expected 0", name, expRspQ.size());
      expRspQ.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic applyStimulus(input int testId);
    case (testId)
      // Simultaneous requests from both masters.
      0: begin
        arDelay = 0; rDelay = 1;
        slvRQ.push_back('{32'h1111_1111, 2'b00});
        slvRQ.push_back('{32'h2222_2222, 2'b00});
`ifdef ARB_ROUND_ROBIN_EN
        expArQ.push_back('{32'h3000_0004, 3'd2});
        expArQ.push_back('{32'h0F00_0000, 3'd2});
        expRspQ.push_back('{0, 32'h1111_1111, 2'b00});
        expRspQ.push_back('{1, 32'h2222_2222, 2'b00});
`else
        expArQ.push_back('{32'h0F00_0000, 3'd2});
        expArQ.push_back('{32'h3000_0004, 3'd2});
        expRspQ.push_back('{1, 32'h1111_1111, 2'b00});
        expRspQ.push_back('{0, 32'h2222_2222, 2'b00});
`endif
        fork
          m0Read(32'h3000_0004);
          m1Read(32'h0F00_0000, 3'd2);
        join
        waitDrain("conflict");
      end
      // Plain IFU read with a slow address accept.
      1: begin
        arDelay = 2; rDelay = 0;
        slvRQ.push_back('{32'hDEAD_BEEF, 2'b00});
        expArQ.push_back('{32'h3000_0000, 3'd2});
        expRspQ.push_back('{0, 32'hDEAD_BEEF, 2'b00});
        m0Read(32'h3000_0000);
        waitDrain("m0 read");
      end
      // LSU write where W is accepted three cycles before AW.
      2: begin
        arDelay = 0; awDelay = 3; wDelay = 0; bDelay = 1;
        slvBQ.push_back(2'b00);
        expAwQ.push_back('{32'h0F00_0010, 3'd2});
        expWQ.push_back('{32'h1234_5678, 4'b1111});
        expRspQ.push_back('{2, 32'h0, 2'b00});
        m1Write(32'h0F00_0010, 32'h1234_5678, 4'b1111);
        waitDrain("m1 write");
        awDelay = 0; bDelay = 0;
      end
      // Error response is passed through untouched.
      3: begin
        slvRQ.push_back('{32'hBADB_AD00, 2'b10});
        expArQ.push_back('{32'h0F00_0020, 3'd1});
        expRspQ.push_back('{1, 32'hBADB_AD00, 2'b10});
        m1Read(32'h0F00_0020, 3'd1);
        waitDrain("m1 slverr");
      end
      // LSU raises read and write together: read goes first.
      4: begin
        slvRQ.push_back('{32'h55AA_55AA, 2'b00});
        slvBQ.push_back(2'b00);
        expArQ.push_back('{32'h0F00_0030, 3'd2});
        expAwQ.push_back('{32'h0F00_0040, 3'd2});
        expWQ.push_back('{32'hCAFE_F00D, 4'b0011});
        expRspQ.push_back('{1, 32'h55AA_55AA, 2'b00});
        expRspQ.push_back('{2, 32'h0, 2'b00});
        fork
          m1Read(32'h0F00_0030, 3'd2);
          m1Write(32'h0F00_0040, 32'hCAFE_F00D, 4'b0011);
        join
        waitDrain("m1 rd+wr");
      end
      // Reset while an IFU read waits in the response phase, then a fresh read.
      5: begin
        rDelay = 6;
        slvRQ.push_back('{32'h0808_0808, 2'b00});
        expArQ.push_back('{32'h3000_0008, 3'd2});
        expRspQ.push_back('{0, 32'h0808_0808, 2'b00});
        m0Read(32'h3000_0008);
        @(negedge clock); #3;
        checkOutput("s_r_ready in RESP", 32'(s_r_ready_o), 32'd1);
        rstn = 0;
        #1;
        checkOutput("abort s_r_ready", 32'(s_r_ready_o), 32'd0);
        checkOutput("abort m0_r_valid", 32'(m0_r_valid_o), 32'd0);
        checkOutput("abort s_ar_valid", 32'(s_ar_valid_o), 32'd0);
        checkOutput("abort s_aw_valid", 32'(s_aw_valid_o), 32'd0);
        expRspQ.delete();
        slvRQ.delete();
        repeat (2) @(negedge clock);
        #2 rstn = 1;
        rDelay = 0;
        @(negedge clock);
        slvRQ.push_back('{32'h0C0C_0C0C, 2'b00});
        expArQ.push_back('{32'h3000_000C, 3'd2});
        expRspQ.push_back('{0, 32'h0C0C_0C0C, 2'b00});
        m0Read(32'h3000_000C);
        waitDrain("post-reset m0 read");
      end
      default: ;
    endcase
  endtask

  initial begin
    rstn = 0;
    m0_ar_addr_i = 32'h3000_0000; m0_ar_valid_i = 1; m0_ar_size_i = 3'd2; m0_r_ready_i = 1;
    m1_ar_addr_i = 32'h0F00_00FF; m1_ar_valid_i = 1; m1_ar_size_i = 3'd2; m1_r_ready_i = 1;
    m1_aw_addr_i = 32'h0F00_00FF; m1_aw_valid_i = 1; m1_aw_size_i = 3'd2;
    m1_w_data_i = 32'hAAAA_AAAA; m1_w_strb_i = 4'hF; m1_w_valid_i = 1; m1_b_ready_i = 1;
    #12;
    checkOutput("rst s_ar_valid", 32'(s_ar_valid_o), 32'd0);
    checkOutput("rst s_ar_addr", s_ar_addr_o, 32'd0);
    checkOutput("rst s_aw_valid", 32'(s_aw_valid_o), 32'd0);
    checkOutput("rst s_aw_addr", s_aw_addr_o, 32'd0);
    checkOutput("rst s_w_valid", 32'(s_w_valid_o), 32'd0);
    checkOutput("rst s_w_data", s_w_data_o, 32'd0);
    checkOutput("rst s_w_strb", 32'(s_w_strb_o), 32'd0);
    checkOutput("rst m0_ar_ready", 32'(m0_ar_ready_o), 32'd0);
    checkOutput("rst m1_aw_ready", 32'(m1_aw_ready_o), 32'd0);
    checkOutput("rst m1_w_ready", 32'(m1_w_ready_o), 32'd0);
    m0_ar_valid_i = 0; m0_ar_addr_i = 0;
    m1_ar_valid_i = 0; m1_ar_addr_i = 0;
    m1_aw_valid_i = 0; m1_aw_addr_i = 0;
    m1_w_valid_i = 0; m1_w_data_i = 0; m1_w_strb_i = 0;
    @(negedge clock); #2 rstn = 1;
    @(negedge clock);
    for (int t = 0; t < 6; t++) applyStimulus(t);
    checkOutput("ar expectations left", 32'(expArQ.size()), 32'd0);
    checkOutput("aw expectations left", 32'(expAwQ.size()), 32'd0);
    checkOutput("w expectations left", 32'(expWQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
